// File: rtl/multiplicador_seq_if.sv
// Bundle of the three handshakes around the operand sequencer:
// operand stream in, multiplier start/done + operands/product, product stream out.
interface multiplicador_seq_if #(
    parameter int N = 4
);
    // Operand stream (valid/ready)
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;

    // Multiplier control unit / datapath (four-phase start/done)
    logic           mul_start;
    logic           mul_done;
    logic [N-1:0]   mul_a;
    logic [N-1:0]   mul_b;
    logic [2*N-1:0] mul_p;

    // Product stream (valid/ready)
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_p;

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_p, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_p
    );

    // Environment side: operand source, multiplier and consumer
    modport master (
        output in_valid, in_a, in_b, mul_done, mul_p, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_p
    );
endinterface

// File: rtl/multiplicador_seq.sv
// Operand sequencer for a shift-add multiplier: accepts operand pairs,
// runs the start/done four-phase handshake and queues products in a
// 2-entry FIFO so a stalled consumer never loses a result.
module multiplicador_seq #(
    parameter int N = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    multiplicador_seq_if.slave bus,
    output logic               busy_o,
    output logic [7:0]         ops_cnt_o
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           mul_start_q;
    logic [N-1:0]   mul_a_q;
    logic [N-1:0]   mul_b_q;
    logic [2*N-1:0] fifo_mem_q [2];
    logic           head_q;
    logic           tail_q;
    logic [1:0]     count_q;
    logic [1:0]     count_d;
    logic [7:0]     ops_cnt_q;

    logic           in_ready;
    logic           accept;
    logic           push;
    logic           pop;

    // A FIFO slot is reserved at accept time, so only accept with room left.
    // The registered count is used, so a same-cycle pop does not help.
    assign in_ready = (state_q == IDLE) && (count_q < 2'd2);
    assign pop      = (count_q != 2'd0) && bus.out_ready;

    // Next-state decode: accept in IDLE, capture on done in RUN,
    // wait for done to fall in RELEASE to close the four-phase handshake.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.mul_done) begin
                    push    = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.mul_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; start is a registered decode so it is glitch-free
    // and drops the cycle after done is captured.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_start_q <= (state_d == RUN);
        end
    end

    // Operand latch: held from one accept to the next, including idle time.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else if (accept) begin
            mul_a_q <= bus.in_a;
            mul_b_q <= bus.in_b;
        end
    end

    // FIFO storage, one register per entry written when the tail points at it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                fifo_mem_q[gi] <= '0;
            end else if (push && (tail_q == 1'(gi))) begin
                fifo_mem_q[gi] <= bus.mul_p;
            end
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, occupancy and the product counter (wraps silently).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
            ops_cnt_q <= 8'd0;
        end else begin
            count_q <= count_d;
            if (push) begin
                tail_q    <= ~tail_q;
                ops_cnt_q <= ops_cnt_q + 8'd1;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_p     = fifo_mem_q[head_q];
    assign busy_o        = (state_q != IDLE);
    assign ops_cnt_o     = ops_cnt_q;
endmodule

// File: tb/tb_multiplicador_seq.sv
// Directed bench for multiplicador_seq with a behavioural start/done multiplier.
module tb_multiplicador_seq;
    localparam int N  = 4;
    localparam int PW = 2 * N;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       busy;
    logic [7:0] ops_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_ops = 0;

    multiplicador_seq_if #(.N(N)) bus();

    multiplicador_seq #(.N(N)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .bus       (bus),
        .busy_o    (busy),
        .ops_cnt_o (ops_cnt)
    );

    always #5 clk = ~clk;

    // Multiplier model: raises done model_delay cycles after start is seen,
    // holds it until start falls.
    int          model_delay = 6;
    int          model_cnt;
    logic        model_done;
    logic [PW-1:0] model_p;
    logic        stale_done = 1'b0;

    assign bus.mul_done = model_done | stale_done;
    assign bus.mul_p    = model_p;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_done <= 1'b0;
            model_p    <= '0;
            model_cnt  <= 0;
        end else if (!model_done) begin
            if (bus.mul_start) begin
                if (model_cnt >= model_delay - 1) begin
                    model_done <= 1'b1;
                    model_p    <= PW'(bus.mul_a) * PW'(bus.mul_b);
                    model_cnt  <= 0;
                end else begin
                    model_cnt <= model_cnt + 1;
                end
            end else begin
                model_cnt <= 0;
            end
        end else if (!bus.mul_start) begin
            model_done <= 1'b0;
        end
    end

    // Consumer monitor: records every product popped.
    logic [PW-1:0] got_q[$];
    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_p);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one pair, wait for acceptance, return on the negedge after accept.
    task automatic send_op(input logic [N-1:0] a, input logic [N-1:0] b, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        for (int i = 0; i < 200; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                @(negedge clk);
                bus.in_valid = 1'b0;
                ok = 1'b1;
                exp_ops++;
                return;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_got(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (got_q.size() >= n) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_ops = 0;
        got_q.delete();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.mul_start !== 1'b0) begin n_bad++; $display("FAIL reset_mul_start: got %0b expected 0", bus.mul_start); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_p !== 8'd0) begin n_bad++; $display("FAIL reset_out_p: got %0d expected 0", bus.out_p); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
        n_cmp++; if (ops_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_ops_cnt: got %0d expected 0", ops_cnt); end
        n_cmp++; if ({bus.mul_a, bus.mul_b} !== 8'd0) begin n_bad++; $display("FAIL reset_operands: got %0h expected 0", {bus.mul_a, bus.mul_b}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_release: in_ready=%0b busy=%0b expected 1/0", bus.in_ready, busy); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        bit ok;
        int k;
        got_q.delete();
        model_delay = 6;
        bus.out_ready = 1'b1;
        send_op(4'd3, 4'd5, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_accept: got timeout expected accept"); end
        n_cmp++; if (bus.mul_a !== 4'd3 || bus.mul_b !== 4'd5) begin n_bad++; $display("FAIL single_operands: got %0d,%0d expected 3,5", bus.mul_a, bus.mul_b); end
        n_cmp++; if (bus.mul_start !== 1'b1 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL single_run: start=%0b busy=%0b in_ready=%0b expected 1/1/0", bus.mul_start, busy, bus.in_ready); end
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_cmp++; if (k !== 7) begin n_bad++; $display("FAIL single_latency: got %0d cycles expected 7", k); end
        n_cmp++; if (bus.out_p !== 8'd15) begin n_bad++; $display("FAIL single_product: got %0d expected 15", bus.out_p); end
        n_cmp++; if (ops_cnt !== 8'd1) begin n_bad++; $display("FAIL single_ops_cnt: got %0d expected 1", ops_cnt); end
        n_cmp++; if (bus.mul_start !== 1'b0 || bus.mul_done !== 1'b1) begin n_bad++; $display("FAIL single_start_before_done: start=%0b done=%0b expected 0/1", bus.mul_start, bus.mul_done); end
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_out_valid_pulse: got %0b expected 0", bus.out_valid); end
        wait_idle(ok);
        n_cmp++; if (!ok || got_q.size() != 1) begin n_bad++; $display("FAIL single_idle: ok=%0b pops=%0d expected 1/1", ok, got_q.size()); end
        $display("test_single: 3x5 -> %0d", bus.out_p);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]  va [3] = '{4'd15, 4'd0, 4'd1};
        logic [N-1:0]  vb [3] = '{4'd15, 4'd7, 4'd1};
        logic [PW-1:0] vp [3] = '{8'd225, 8'd0, 8'd1};
        bit ok;
        got_q.delete();
        model_delay = 3;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_a = va[i];
            bus.in_b = vb[i];
            ok = 1'b0;
            for (int c = 0; c < 100; c++) begin
                if (bus.in_ready) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_accept%0d: got timeout expected accept", i); end
            n_cmp++; if (bus.mul_done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_low%0d: got %0b expected 0", i, bus.mul_done); end
            n_cmp++; if (ops_cnt !== 8'(exp_ops)) begin n_bad++; $display("FAIL b2b_ops%0d: got %0d expected %0d", i, ops_cnt, exp_ops); end
            @(posedge clk);
            @(negedge clk);
            exp_ops++;
        end
        bus.in_valid = 1'b0;
        wait_got(3, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_complete: got %0d products expected 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== vp[i]) begin n_bad++; $display("FAIL b2b_product%0d: got %0d expected %0d", i, got_q[i], vp[i]); end
            $display("test_back_to_back: product %0d = %0d", i, got_q[i]);
        end
    endtask

    task automatic test_stall();
        bit ok;
        got_q.delete();
        bus.out_ready = 1'b0;
        send_op(4'd2, 4'd3, ok); wait_idle(ok);
        send_op(4'd4, 4'd4, ok); wait_idle(ok);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_p !== 8'd6) begin n_bad++; $display("FAIL stall_head: valid=%0b p=%0d expected 1/6", bus.out_valid, bus.out_p); end
        bus.in_valid = 1'b1;
        bus.in_a = 4'd5;
        bus.in_b = 4'd5;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL stall_blocked%0d: in_ready=%0b busy=%0b expected 0/0", i, bus.in_ready, busy); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_p !== 8'd16) begin n_bad++; $display("FAIL stall_reenable: in_ready=%0b p=%0d expected 1/16", bus.in_ready, bus.out_p); end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp_ops++;
        n_cmp++; if (busy !== 1'b1 || bus.mul_a !== 4'd5) begin n_bad++; $display("FAIL stall_accept: busy=%0b mul_a=%0d expected 1/5", busy, bus.mul_a); end
        wait_idle(ok);
        n_cmp++; if (bus.out_p !== 8'd16 || ops_cnt !== 8'(exp_ops)) begin n_bad++; $display("FAIL stall_hold: p=%0d ops=%0d expected 16/%0d", bus.out_p, ops_cnt, exp_ops); end
        bus.out_ready = 1'b1;
        wait_got(3, ok);
        bus.out_ready = 1'b0;
        n_cmp++; if (got_q.size() != 3 || got_q[0] !== 8'd6 || got_q[1] !== 8'd16 || got_q[2] !== 8'd25) begin
            n_bad++; $display("FAIL stall_order: got %p expected 6,16,25", got_q);
        end
        $display("test_stall: order %p", got_q);
    endtask

    task automatic test_push_pop();
        bit ok;
        got_q.delete();
        bus.out_ready = 1'b0;
        send_op(4'd7, 4'd3, ok); wait_idle(ok);
        send_op(4'd9, 4'd9, ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.mul_start && bus.mul_done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL pushpop_done: got timeout expected done"); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'd21) begin n_bad++; $display("FAIL pushpop_popped: got %p expected 21", got_q); end
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_p !== 8'd81) begin n_bad++; $display("FAIL pushpop_head: valid=%0b p=%0d expected 1/81", bus.out_valid, bus.out_p); end
        n_cmp++; if (ops_cnt !== 8'(exp_ops)) begin n_bad++; $display("FAIL pushpop_ops: got %0d expected %0d", ops_cnt, exp_ops); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL pushpop_count: valid=%0b expected 0 after one pop", bus.out_valid); end
        wait_idle(ok);
        $display("test_push_pop: popped %0d, next head 81", got_q[0]);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus.out_ready = 1'b0;
        send_op(4'd2, 4'd2, ok); wait_idle(ok);
        send_op(4'd6, 4'd6, ok);
        @(negedge clk);
        n_cmp++; if (bus.mul_start !== 1'b1 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: start=%0b valid=%0b expected 1/1", bus.mul_start, bus.out_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.mul_start !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_start_busy: start=%0b busy=%0b expected 0/0", bus.mul_start, busy); end
        n_cmp++; if (bus.out_valid !== 1'b0 || ops_cnt !== 8'd0) begin n_bad++; $display("FAIL midrst_fifo_cnt: valid=%0b ops=%0d expected 0/0", bus.out_valid, ops_cnt); end
        n_cmp++; if (bus.mul_a !== 4'd0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_misc: mul_a=%0d in_ready=%0b expected 0/1", bus.mul_a, bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_ops = 0;
        got_q.delete();
        bus.out_ready = 1'b1;
        send_op(4'd2, 4'd7, ok);
        wait_got(1, ok);
        n_cmp++; if (!ok || got_q[0] !== 8'd14 || ops_cnt !== 8'd1) begin n_bad++; $display("FAIL midrst_next: ok=%0b ops=%0d expected 14 and ops 1", ok, ops_cnt); end
        wait_idle(ok);
        $display("test_reset_mid: next op product 14, ops_cnt=%0d", ops_cnt);
    endtask

    task automatic test_wrap();
        bit ok;
        int ones;
        apply_reset();
        model_delay = 1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send_op(4'd1, 4'd1, ok);
            wait_idle(ok);
            if (i == 254) begin
                n_cmp++; if (ops_cnt !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d expected 255", ops_cnt); end
            end
        end
        n_cmp++; if (ops_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d expected 0", ops_cnt); end
        ones = 0;
        foreach (got_q[i]) if (got_q[i] === 8'd1) ones++;
        n_cmp++; if (ones != 256 || got_q.size() != 256) begin n_bad++; $display("FAIL wrap_products: got %0d ones of %0d expected 256", ones, got_q.size()); end
        @(negedge clk);
        stale_done = 1'b1;
        repeat (3) @(negedge clk);
        stale_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (ops_cnt !== 8'd0 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL wrap_stale: ops=%0d valid=%0b busy=%0b expected 0/0/0", ops_cnt, bus.out_valid, busy); end
        $display("test_wrap: 256 ops, ops_cnt=%0d", ops_cnt);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_push_pop();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
